// File: rtl/if_stage.sv
// Instruction-fetch front end: PC generation, synchronous ROM request and a
// show-ahead prefetch FIFO that absorbs ID stalls and is flushed on redirect.
module if_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       rom_ce_o,
    output logic [ADDR_W-1:0]          rom_addr_o,
    input  logic [DATA_W-1:0]          rom_data_i,
    input  logic                       stall_i,
    input  logic                       branch_flag_i,
    input  logic [ADDR_W-1:0]          branch_target_i,
    output logic                       id_valid_o,
    output logic [ADDR_W-1:0]          id_pc_o,
    output logic [DATA_W-1:0]          id_inst_o,
    output logic [$clog2(DEPTH):0]     occ_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + DATA_W;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [ENT_W-1:0]  mem_q [DEPTH];

    logic [CNT_W:0]    used;
    logic              issue;
    logic              valid;
    logic              push;
    logic              pop;
    logic              wr_en;
    logic [ENT_W-1:0]  head;

    // No credit is taken for a same-cycle pop, so a slot is always free for the return.
    assign used  = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign issue = !rst && !branch_flag_i && (used < (CNT_W+1)'(DEPTH));
    assign valid = (count_q != '0);
    assign push  = inflight_q;
    assign pop   = valid && !stall_i;
    assign wr_en = !rst && !branch_flag_i && push;
    assign head  = mem_q[rptr_q];

    always_comb begin
        pc_d          = pc_q;
        count_d       = count_q;
        rptr_d        = rptr_q;
        wptr_d        = wptr_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        if (branch_flag_i) begin
            pc_d       = branch_target_i;
            count_d    = '0;
            rptr_d     = '0;
            wptr_d     = '0;
            inflight_d = 1'b0;
        end else begin
            if (issue) begin
                pc_d          = pc_q + ADDR_W'(PC_STEP);
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
            end else begin
                inflight_d = 1'b0;
            end
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            count_q       <= '0;
            rptr_q        <= '0;
            wptr_q        <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            count_q       <= count_d;
            rptr_q        <= rptr_d;
            wptr_q        <= wptr_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q] <= {inflight_pc_q, rom_data_i};
    end

    assign rom_ce_o   = issue;
    assign rom_addr_o = pc_q;
    assign id_valid_o = valid;
    assign id_pc_o    = valid ? head[ENT_W-1:DATA_W] : '0;
    assign id_inst_o  = valid ? head[DATA_W-1:0]     : '0;
    assign occ_o      = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a 32-bit/DEPTH=4 instance for stream, stall,
// flush and reset cases, and an 8-bit/DEPTH=2 instance for PC and pointer wrap.
module tb_if_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, expv);
        end
    endtask

    function automatic logic [31:0] rom1(input logic [31:0] a);
        return a ^ 32'hDEAD0000;
    endfunction

    // ---------------- main instance ----------------
    logic        rst, stall, br, ce, valid;
    logic [31:0] tgt, addr, rdata, id_pc, id_inst;
    logic [2:0]  occ;

    if_stage #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(4)) u_dut (
        .clk(clk), .rst(rst), .rom_ce_o(ce), .rom_addr_o(addr), .rom_data_i(rdata),
        .stall_i(stall), .branch_flag_i(br), .branch_target_i(tgt),
        .id_valid_o(valid), .id_pc_o(id_pc), .id_inst_o(id_inst), .occ_o(occ)
    );

    always @(posedge clk) if (ce) rdata <= rom1(addr);

    // ---------------- wrap instance ----------------
    logic        rst2, stall2, br2, ce2, v2, done2;
    logic [7:0]  tgt2, addr2, pc2, exp2;
    logic [15:0] rdata2, inst2;
    logic [1:0]  occ2;
    int          pops2;

    if_stage #(.ADDR_W(8), .DATA_W(16), .DEPTH(2), .RESET_PC(8'hFC), .PC_STEP(4)) u_wrap (
        .clk(clk), .rst(rst2), .rom_ce_o(ce2), .rom_addr_o(addr2), .rom_data_i(rdata2),
        .stall_i(stall2), .branch_flag_i(br2), .branch_target_i(tgt2),
        .id_valid_o(v2), .id_pc_o(pc2), .id_inst_o(inst2), .occ_o(occ2)
    );

    always @(posedge clk) if (ce2) rdata2 <= {8'h5A, addr2};

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst2 = 1'b1; stall2 = 1'b0; br2 = 1'b0; tgt2 = '0;
        exp2 = 8'hFC; pops2 = 0; done2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst2 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) nxt();
            stall2 = ((k % 7) == 5) || ((k % 7) == 6);
            mid();
            if (k == 0) begin
                check("wrap_ce0", ce2, 1'b1);
                check("wrap_addr0", addr2, 8'hFC);
            end
            if (k == 1) begin
                check("wrap_ce1", ce2, 1'b1);
                check("wrap_addr1", addr2, 8'h00);
            end
            if (v2 && !stall2) begin
                check("wrap_pc", pc2, exp2);
                check("wrap_inst", inst2, {8'h5A, exp2});
                exp2 = exp2 + 8'd4;
                pops2++;
            end
        end
        check("wrap_pops", (pops2 >= 12), 1'b1);
        done2 = 1'b1;
    end

    initial begin
        rst = 1'b1; stall = 1'b0; br = 1'b0; tgt = '0;
        repeat (3) @(posedge clk);
        mid();
        check("rst_ce", ce, 1'b0);
        check("rst_addr", addr, 32'h0);
        check("rst_valid", valid, 1'b0);
        check("rst_pc", id_pc, 32'h0);
        check("rst_inst", id_inst, 32'h0);
        check("rst_occ", occ, 3'd0);

        // stream
        nxt(); rst = 1'b0; mid();                       // cycle 0
        check("c0_ce", ce, 1'b1);
        check("c0_addr", addr, 32'h0);
        check("c0_valid", valid, 1'b0);
        nxt(); mid();                                   // cycle 1
        check("c1_addr", addr, 32'h4);
        check("c1_valid", valid, 1'b0);
        nxt(); mid();                                   // cycle 2
        check("c2_addr", addr, 32'h8);
        check("c2_valid", valid, 1'b1);
        check("c2_pc", id_pc, 32'h0);
        check("c2_inst", id_inst, rom1(32'h0));
        check("c2_occ", occ, 3'd1);

        // stall fill
        nxt(); stall = 1'b1; mid();                     // cycle 3
        check("c3_pc", id_pc, 32'h4);
        check("c3_ce", ce, 1'b1);
        check("c3_addr", addr, 32'hC);
        check("c3_occ", occ, 3'd1);
        nxt(); mid();                                   // cycle 4
        check("c4_ce", ce, 1'b1);
        check("c4_addr", addr, 32'h10);
        check("c4_occ", occ, 3'd2);
        nxt(); mid();                                   // cycle 5
        check("c5_ce", ce, 1'b0);
        check("c5_occ", occ, 3'd3);
        for (int k = 6; k <= 12; k++) begin
            nxt(); mid();
            check("stall_occ", occ, 3'd4);
            check("stall_ce", ce, 1'b0);
            check("stall_pc", id_pc, 32'h4);
        end
        nxt(); stall = 1'b0; mid();                     // cycle 13
        check("c13_pc", id_pc, 32'h4);
        check("c13_ce", ce, 1'b0);
        check("c13_occ", occ, 3'd4);
        nxt(); mid();                                   // cycle 14
        check("c14_pc", id_pc, 32'h8);
        check("c14_ce", ce, 1'b1);
        check("c14_addr", addr, 32'h14);
        check("c14_occ", occ, 3'd3);
        for (int k = 15; k <= 20; k++) begin
            nxt(); mid();
            check("rel_pc", id_pc, 32'(12 + 4 * (k - 15)));
            check("rel_inst", id_inst, rom1(32'(12 + 4 * (k - 15))));
            check("rel_occ", occ, 3'd2);
            check("rel_addr", addr, 32'(20 + 4 * (k - 14)));
        end

        // flush with 3 buffered and one in flight
        nxt(); stall = 1'b1; mid();                     // cycle 21
        check("c21_pc", id_pc, 32'd36);
        check("c21_addr", addr, 32'd48);
        nxt(); br = 1'b1; tgt = 32'h100; mid();         // cycle 22 = b
        check("b_occ", occ, 3'd3);
        check("b_ce", ce, 1'b0);
        nxt(); br = 1'b0; stall = 1'b0; mid();          // b+1
        check("b1_occ", occ, 3'd0);
        check("b1_valid", valid, 1'b0);
        check("b1_addr", addr, 32'h100);
        check("b1_ce", ce, 1'b1);
        nxt(); mid();                                   // b+2
        check("b2_valid", valid, 1'b0);
        check("b2_addr", addr, 32'h104);
        nxt(); mid();                                   // b+3
        check("b3_valid", valid, 1'b1);
        check("b3_pc", id_pc, 32'h100);
        check("b3_inst", id_inst, rom1(32'h100));
        check("b3_occ", occ, 3'd1);
        nxt(); mid();
        check("b4_pc", id_pc, 32'h104);

        // redirect colliding with pop and return
        nxt(); br = 1'b1; tgt = 32'h200; mid();         // cycle 27
        check("col_valid", valid, 1'b1);
        check("col_pc", id_pc, 32'h108);
        nxt(); br = 1'b0; mid();
        check("col1_occ", occ, 3'd0);
        check("col1_valid", valid, 1'b0);
        check("col1_addr", addr, 32'h200);
        nxt(); mid();
        check("col2_valid", valid, 1'b0);
        check("col2_occ", occ, 3'd0);
        nxt(); stall = 1'b1; mid();                     // cycle 30
        check("col3_valid", valid, 1'b1);
        check("col3_pc", id_pc, 32'h200);
        check("col3_inst", id_inst, rom1(32'h200));

        // mid-run reset with 3 buffered and one in flight
        nxt(); mid();
        check("pre_rst_occ2", occ, 3'd2);
        nxt(); rst = 1'b1; mid();                       // cycle 32
        check("pre_rst_occ3", occ, 3'd3);
        check("in_rst_ce", ce, 1'b0);
        nxt(); rst = 1'b0; stall = 1'b0; mid();
        check("mr_occ", occ, 3'd0);
        check("mr_valid", valid, 1'b0);
        check("mr_pc", id_pc, 32'h0);
        check("mr_inst", id_inst, 32'h0);
        check("mr_addr", addr, 32'h0);
        check("mr_ce", ce, 1'b1);
        nxt(); mid();
        check("mr1_valid", valid, 1'b0);
        check("mr1_addr", addr, 32'h4);
        nxt(); mid();
        check("mr2_valid", valid, 1'b1);
        check("mr2_pc", id_pc, 32'h0);
        check("mr2_inst", id_inst, rom1(32'h0));
        nxt(); mid();
        check("mr3_pc", id_pc, 32'h4);
        check("mr3_occ", occ, 3'd1);

        for (int i = 0; i < 200 && !done2; i++) @(posedge clk);
        check("wrap_done", done2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
